// File: rtl/mem_access_stage_pkg.sv
// Shared pipeline package for the MEM stage.
//   - bus_state_e : encoding of the data-memory bus FSM
//   - REG_ADDR_W  : width of a register-file destination index
//   - DATA_W      : width of the WB data payload and of bus words
//   - word_addr() : byte address -> word-aligned bus address
package mem_access_stage_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_WAIT_R = 2'b10
  } bus_state_e;

  // The bus only carries word addresses; the two byte-offset bits are zeroed.
  function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] byte_addr);
    return {byte_addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_access_stage_mem_bus_fsm.sv
// Data-memory bus sequencer for the MEM stage.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   acc          : aligned, non-killed load or store is present
//   mis          : misaligned, non-killed load or store is present
//   store        : the present access is a store (stores win over loads)
//   gnt, rvalid  : bus grant / read-data-valid from memory
//   state        : current FSM state (debug visibility)
//   req          : bus request (combinational)
//   stall        : hold request for the upstream pipeline (combinational)
//   rd_done      : a load completes with read data this cycle
//   addr_err_now : misaligned access being retired this cycle
//   bus_err_now  : load timing out this cycle
// Handshake: a request is transferred in any cycle where req && gnt. Read data
// is transferred in any WAIT_R cycle where rvalid is high; rvalid is ignored
// in every other state, including the cycle that carries gnt.
module mem_bus_fsm
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       acc,
  input  logic       mis,
  input  logic       store,
  input  logic       gnt,
  input  logic       rvalid,
  output bus_state_e state,
  output logic       req,
  output logic       stall,
  output logic       rd_done,
  output logic       addr_err_now,
  output logic       bus_err_now
);

  logic [TMO_W-1:0] tmo_cnt;
  logic             in_idle;
  logic             in_req;
  logic             in_wait;
  logic             store_gnt;
  logic             tmo;

  assign in_idle   = (state == ST_IDLE);
  assign in_req    = (state == ST_REQ);
  assign in_wait   = (state == ST_WAIT_R);
  assign store_gnt = gnt & store;
  // Timeout fires on the last allowed WAIT_R cycle; rvalid in that cycle still wins.
  assign tmo       = in_wait & ~rvalid & (tmo_cnt == TMO_W'(TIMEOUT - 1));

  // req/stall are gated with rst_n so an asserted reset drops them at once,
  // even while the upstream EX/MEM outputs still show an access.
  assign req   = rst_n & ((in_idle & acc) | in_req);
  // A store granted in IDLE or REQ completes in that same cycle, so the
  // pipeline must be released on that edge.
  assign stall = rst_n & ((in_idle & acc & ~store_gnt) |
                          (in_req & ~store_gnt) |
                          (in_wait & ~rvalid & ~tmo));

  assign rd_done      = in_wait & rvalid;
  assign addr_err_now = in_idle & mis;
  assign bus_err_now  = tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            if (!gnt) begin
              state <= ST_REQ;
            end else if (!store) begin
              state   <= ST_WAIT_R;
              tmo_cnt <= '0;
            end
          end
        end
        ST_REQ: begin
          if (gnt) begin
            if (store) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_WAIT_R;
              tmo_cnt <= '0;
            end
          end
        end
        ST_WAIT_R: begin
          if (rvalid || tmo) begin
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues word loads/stores on a req/gnt/rvalid bus,
// stalls upstream while an access is outstanding and registers the WB payload.
// Ports:
//   clk, rst_n                        : clock, asynchronous active-low reset
//   MemWr_M, MemtoReg_M, RegWr_M      : store / load / register-write controls
//   RegWrDst_M, result_M, rt_data_M   : destination, ALU result (byte address), store data
//   if_overflow_M                     : kills memory access and register write
//   dmem_req/we/addr/wdata            : bus request side (combinational)
//   dmem_gnt, dmem_rvalid, dmem_rdata : bus response side
//   stall_M                           : upstream hold (combinational)
//   wb_valid/RegWr/RegWrDst/data      : registered WB payload
//   addr_err, bus_err                 : registered 1-cycle error pulses
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int TMO_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MemWr_M,
  input  logic                  MemtoReg_M,
  input  logic                  RegWr_M,
  input  logic [REG_ADDR_W-1:0] RegWrDst_M,
  input  logic [DATA_W-1:0]     result_M,
  input  logic [DATA_W-1:0]     rt_data_M,
  input  logic                  if_overflow_M,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [DATA_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  stall_M,
  output logic                  wb_valid,
  output logic                  wb_RegWr,
  output logic [REG_ADDR_W-1:0] wb_RegWrDst,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  addr_err,
  output logic                  bus_err
);

  logic       mem_op;
  logic       aligned;
  logic       acc;
  logic       mis;
  logic       rd_done;
  logic       addr_err_now;
  logic       bus_err_now;
  bus_state_e bus_state;

  assign mem_op  = (MemWr_M | MemtoReg_M) & ~if_overflow_M;
  assign aligned = (result_M[1:0] == 2'b00);
  assign acc     = mem_op & aligned;
  assign mis     = mem_op & ~aligned;

  mem_bus_fsm #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_bus_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc          (acc),
    .mis          (mis),
    .store        (MemWr_M),
    .gnt          (dmem_gnt),
    .rvalid       (dmem_rvalid),
    .state        (bus_state),
    .req          (dmem_req),
    .stall        (stall_M),
    .rd_done      (rd_done),
    .addr_err_now (addr_err_now),
    .bus_err_now  (bus_err_now)
  );

  // Request fields come straight from EX/MEM, which is held while stalled,
  // so they stay stable until the grant.
  assign dmem_we    = MemWr_M;
  assign dmem_addr  = word_addr(result_M);
  assign dmem_wdata = rt_data_M;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_RegWr    <= 1'b0;
      wb_RegWrDst <= '0;
      wb_data     <= '0;
      addr_err    <= 1'b0;
      bus_err     <= 1'b0;
    end else if (stall_M) begin
      // Bubble into WB; data/destination are don't-care and simply hold.
      wb_valid <= 1'b0;
      wb_RegWr <= 1'b0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      wb_valid    <= 1'b1;
      wb_RegWr    <= RegWr_M & ~if_overflow_M & ~addr_err_now & ~bus_err_now;
      wb_RegWrDst <= RegWrDst_M;
      wb_data     <= rd_done ? dmem_rdata : result_M;
      addr_err    <= addr_err_now;
      bus_err     <= bus_err_now;
    end
  end

endmodule
